adder_pipe_param: RTL and testbench
===================================

ADDER_PIPE_PARAM -- requirements
Module: adder_pipe_param

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter STAGES, default 4, pipeline depth and number of carry segments; WIDTH SHALL be an integer multiple of STAGES.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand set present this cycle.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 cin_a  input  WIDTH  operand A.
REQ-008 cin_b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in (borrow-in when sub=1).
REQ-010 sub  input  1  mode: 0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  raw carry out of MSB (add: carry; sub: 1 = no borrow).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Operands SHALL be split into STAGES segments of SEG=WIDTH/STAGES bits, LSB segment first; stage k SHALL add segment k using the registered carry of stage k-1.
REQ-017 Effective B SHALL be cin_b XOR {WIDTH{sub}}, effective carry-in cin XOR sub; add yields A+B+cin, sub yields A-B-cin, both modulo 2^WIDTH.
REQ-018 Unconsumed upper operand segments SHALL be delayed and completed lower sum segments deskewed so all bits of one transaction emerge together.
REQ-019 Latency SHALL be exactly STAGES cycles from an accepted transfer (in_valid && in_ready) to out_valid, absent stalls.
REQ-020 Pipeline advance enable SHALL be en = !out_valid || out_ready; in_ready SHALL equal en (combinational, no bubble collapse).
REQ-021 When en=0 every stage register, valid bit and output SHALL hold unchanged; sum/cout/ovf SHALL remain stable while out_valid && !out_ready.
REQ-022 A valid bit SHALL travel with each transaction; stages carrying no transaction SHALL not assert out_valid.
REQ-023 Full throughput: one transaction accepted per cycle when out_ready is held high; back-to-back transactions SHALL not interact (carries never cross transactions).
REQ-024 ovf SHALL be carry-into-MSB XOR carry-out-of-MSB of the final segment.
REQ-025 STAGES=1 SHALL degenerate to a single registered adder with latency 1; STAGES=WIDTH SHALL be legal (1-bit segments).
REQ-026 Transfer accepted and result consumed in the same cycle SHALL both complete.

Reset
REQ-027 On rst high, all valid bits SHALL clear immediately; out_valid=0, sum=0, cout=0, ovf=0 asynchronously.
REQ-028 Transactions in flight at reset SHALL be discarded, never emitted.
REQ-029 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-030 Datapath registers other than valid bits MAY be reset; outputs SHALL be zero while out_valid=0 after reset until the first result.

Structure
REQ-031 Shared package adder_pipe_pkg SHALL hold default WIDTH/STAGES constants and the SEG derivation function.
REQ-032 One sub-module adder_seg (SEG-bit adder with carry-in, carry-out and MSB carry-in tap) SHALL be instantiated STAGES times via generate.
REQ-033 Parameter legality (WIDTH % STAGES == 0, STAGES >= 1) SHALL be checked at elaboration.

Verification (WIDTH=16, STAGES=4)
REQ-034 A=0xFFFF, B=0x0001, cin=0, sub=0 -> 4 cycles later sum=0x0000, cout=1, ovf=0 (carry ripples all segments).
REQ-035 A=0x7FFF, B=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1; A=0x0003, B=0x0005, sub=1, cin=0 -> sum=0xFFFE, cout=0, ovf=0.
REQ-036 Streaming 1000 random transactions, out_ready=1 -> one result per cycle, in order, matching A+B+cin / A-B-cin model.
REQ-037 Random out_ready with 50% duty -> no loss, no duplication, outputs stable while stalled, in_ready low exactly when out_valid && !out_ready.
REQ-038 rst asserted for one cycle with 3 transactions in flight -> out_valid drops asynchronously, none of the 3 emerge; next accepted transaction returns after exactly 4 cycles.

Source files
------------

// File: rtl/adder_pipe_pkg.sv
// Shared constants and helpers for the segmented pipelined adder.
package adder_pipe_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    // Bits per carry segment; guards against a zero stage count so that the
    // legality check in the top module reports the problem instead of a
    // divide-by-zero during elaboration.
    function automatic int seg_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

endpackage

// File: rtl/adder_seg.sv
// One carry segment: SEG-bit adder with carry-in, carry-out and the carry
// that enters its most significant bit (needed for signed overflow).
module adder_seg
    import adder_pipe_pkg::*;
#(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb
);

    logic [SEG:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
    assign s     = full[SEG-1:0];
    assign co    = full[SEG];
    // The MSB sum bit is a ^ b ^ carry-in, so the carry-in is recoverable.
    assign c_msb = a[SEG-1] ^ b[SEG-1] ^ full[SEG-1];

endmodule

// File: rtl/adder_pipe_param.sv
// Pipelined add/subtract unit. The operands are cut into STAGES carry
// segments; each pipeline stage adds one segment using the carry registered
// by the previous stage. Unconsumed operand bits travel forward with the
// transaction and finished sum bits accumulate, so the whole result leaves
// the last stage at once. A single enable stalls every stage together.
module adder_pipe_param
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] cin_a,
    input  logic [WIDTH-1:0] cin_b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
        $error("adder_pipe_param: WIDTH must be a positive multiple of STAGES");
    end

    // Whole pipeline moves when the output slot is empty or being drained.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO   = k * SEG;
        localparam int IN_W = WIDTH - LO;

        logic [IN_W-1:0]     a_in;
        logic [IN_W-1:0]     b_in;
        logic                c_in;
        logic                vld_in;
        logic [SEG-1:0]      seg_s;
        logic                seg_co;
        logic                seg_cmsb;
        logic [LO+SEG-1:0]   s_next;
        logic [LO+SEG-1:0]   s_p;
        logic                c_p;
        logic                vld_p;

        if (k == 0) begin : g_head
            // Subtraction is A + ~B + ~borrow.
            assign a_in   = cin_a;
            assign b_in   = cin_b ^ {WIDTH{sub}};
            assign c_in   = cin ^ sub;
            assign vld_in = in_valid;
            assign s_next = seg_s;
        end else begin : g_body
            assign a_in   = g_stage[k-1].g_up.a_p;
            assign b_in   = g_stage[k-1].g_up.b_p;
            assign c_in   = g_stage[k-1].c_p;
            assign vld_in = g_stage[k-1].vld_p;
            assign s_next = {seg_s, g_stage[k-1].s_p};
        end

        adder_seg #(.SEG(SEG)) u_seg (
            .a     (a_in[SEG-1:0]),
            .b     (b_in[SEG-1:0]),
            .ci    (c_in),
            .s     (seg_s),
            .co    (seg_co),
            .c_msb (seg_cmsb)
        );

        // ---- stage k register boundary ----
        // Valid follows every advance; data loads only with a real transaction
        // so idle slots keep their reset value.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_p <= 1'b0;
                c_p   <= 1'b0;
                s_p   <= '0;
            end else if (en) begin
                vld_p <= vld_in;
                if (vld_in) begin
                    c_p <= seg_co;
                    s_p <= s_next;
                end
            end
        end

        if (k < STAGES - 1) begin : g_up
            logic [IN_W-SEG-1:0] a_p;
            logic [IN_W-SEG-1:0] b_p;
            logic                tap_unused;

            // Only the MSB segment needs its internal carry tap.
            assign tap_unused = seg_cmsb;

            // Delay the operand segments that later stages still have to add.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_p <= '0;
                    b_p <= '0;
                end else if (en && vld_in) begin
                    a_p <= a_in[IN_W-1:SEG];
                    b_p <= b_in[IN_W-1:SEG];
                end
            end
        end else begin : g_tail
            logic ovf_p;

            // Signed overflow: carry into the MSB differs from carry out of it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_p <= 1'b0;
                end else if (en && vld_in) begin
                    ovf_p <= seg_cmsb ^ seg_co;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_p;
    assign sum       = g_stage[STAGES-1].s_p;
    assign cout      = g_stage[STAGES-1].c_p;
    assign ovf       = g_stage[STAGES-1].g_tail.ovf_p;

endmodule

// File: tb/tb_adder_pipe_param.sv
// Bench for adder_pipe_param (WIDTH=16, STAGES=4): directed corner cases,
// random streaming, random back-pressure and a mid-flight reset, all checked
// against an arithmetic model of a STAGES-deep stall-together pipeline.
module tb_adder_pipe_param;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] cin_a;
    logic [W-1:0] cin_b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    adder_pipe_param #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cin_a     (cin_a),
        .cin_b     (cin_b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: S result slots that shift together whenever the pipe advances.
    logic         mv   [S];
    logic [W-1:0] msum [S];
    logic         mco  [S];
    logic         mov  [S];
    int           n_acc = 0;
    int           n_got = 0;
    logic         zero_phase;
    logic         prev_stall;
    logic [W-1:0] prev_sum;
    logic         prev_co;
    logic         prev_ov;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned result for sum/cout, signed for ovf.
    task automatic ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic sb,
                            output logic [W-1:0] s, output logic co, output logic ov);
        int ua, ub, r, sa, sbv, rs;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (!sb) begin
            r  = ua + ub + int'(ci);
            rs = sa + sbv + int'(ci);
            co = (r > 65535);
        end else begin
            r  = ua - ub - int'(ci);
            rs = sa - sbv - int'(ci);
            co = (r >= 0);
        end
        s  = r[W-1:0];
        ov = (rs > 32767) || (rs < -32768);
    endtask

    task automatic clear_model();
        for (int k = 0; k < S; k++) begin
            mv[k]   = 1'b0;
            msum[k] = '0;
            mco[k]  = 1'b0;
            mov[k]  = 1'b0;
        end
        zero_phase = 1'b1;
        prev_stall = 1'b0;
    endtask

    // One clock: drive at the falling edge, check, advance the model, wait.
    task automatic cycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sb, input logic ordy);
        logic [W-1:0] es;
        logic         eco, eov, en_m;
        in_valid  = iv;
        cin_a     = a;
        cin_b     = b;
        cin       = ci;
        sub       = sb;
        out_ready = ordy;
        #1;
        en_m = !mv[S-1] || ordy;
        chk("in_ready", in_ready, en_m);
        chk("out_valid", out_valid, mv[S-1]);
        if (mv[S-1]) begin
            chk("sum", sum, msum[S-1]);
            chk("cout", cout, mco[S-1]);
            chk("ovf", ovf, mov[S-1]);
            zero_phase = 1'b0;
        end else if (zero_phase) begin
            chk("sum_idle_zero", sum, 0);
            chk("cout_idle_zero", cout, 0);
            chk("ovf_idle_zero", ovf, 0);
        end
        if (prev_stall) begin
            chk("sum_stable", sum, prev_sum);
            chk("cout_stable", cout, prev_co);
            chk("ovf_stable", ovf, prev_ov);
        end
        prev_stall = out_valid && !ordy;
        prev_sum   = sum;
        prev_co    = cout;
        prev_ov    = ovf;
        if (out_valid && ordy) n_got++;
        if (en_m) begin
            for (int k = S - 1; k > 0; k--) begin
                mv[k]   = mv[k-1];
                msum[k] = msum[k-1];
                mco[k]  = mco[k-1];
                mov[k]  = mov[k-1];
            end
            ref_calc(a, b, ci, sb, es, eco, eov);
            mv[0]   = iv;
            msum[0] = es;
            mco[0]  = eco;
            mov[0]  = eov;
            if (iv) n_acc++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    endtask

    task automatic expect_now(input string tag, input logic [W-1:0] es, input logic eco, input logic eov);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, eco);
        chk({tag, "_ovf"}, ovf, eov);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        cin_a     = '0;
        cin_b     = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // Carry ripples through all four segments.
        cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        idle(3);
        expect_now("ripple", 16'h0000, 1'b1, 1'b0);

        // Positive overflow into the sign bit.
        cycle(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        idle(3);
        expect_now("pos_ovf", 16'h8000, 1'b0, 1'b1);

        // Subtract with borrow out.
        cycle(1'b1, 16'h0003, 16'h0005, 1'b0, 1'b1, 1'b1);
        idle(3);
        expect_now("sub_borrow", 16'hFFFE, 1'b0, 1'b0);

        // Borrow-in alone on a zero subtraction.
        cycle(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1);
        idle(3);
        expect_now("sub_bin", 16'hFFFF, 1'b0, 1'b0);

        // Full-rate streaming.
        for (int i = 0; i < 1000; i++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);

        // Random back-pressure and random gaps.
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

        idle(S + 4);
        chk("no_loss_no_dup", n_got, n_acc);

        // Fill the pipe, then reset with transactions in flight.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_sum", sum, 0);
        chk("async_rst_cout", cout, 0);
        chk("async_rst_ovf", ovf, 0);
        chk("async_rst_in_ready", in_ready, 1);
        clear_model();
        @(posedge clk);
        #1;
        chk("rst_hold_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        cycle(1'b1, 16'h1234, 16'h0101, 1'b1, 1'b0, 1'b1);
        idle(3);
        expect_now("post_rst", 16'h1336, 1'b0, 1'b0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
